dir_input_ctrl: RTL and testbench

DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

---
 rtl/dir_input_ctrl.sv | 96 +++++++++
 tb/tb_dir_input_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dir_input_ctrl.sv
// Snake direction input controller: arbitrates button pulses, filters reversals, queues turns, commits on game_tick.
// All outputs registered, one cycle after the causing input; a full queue drops new turns unless a tick pops the same cycle.
module dir_input_ctrl #(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up_pulse,
    input  logic       btn_down_pulse,
    input  logic       btn_left_pulse,
    input  logic       btn_right_pulse,
    input  logic       game_active,
    input  logic       game_tick,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic       start_pulse,
    output logic       drop_pulse,
    output logic [2:0] queue_count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] LAST_PTR  = 2'(QUEUE_DEPTH - 1);
    localparam logic [2:0] FULL_CNT  = 3'(QUEUE_DEPTH);
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    state_t          state, state_nxt;
    logic [3:0][1:0] q;
    logic [1:0]      rd_ptr, wr_ptr, newest_ptr;
    logic [1:0]      win, ref_dir;
    logic            any_btn, running, leaving, accept, full, pop, push, drop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        state_nxt  = game_active ? RUN : IDLE;
        any_btn    = btn_up_pulse | btn_down_pulse | btn_left_pulse | btn_right_pulse;
        running    = (state == RUN) && game_active;
        leaving    = (state == RUN) && !game_active;
        win        = DIR_RIGHT;
        if (btn_up_pulse)
            win = DIR_UP;
        else if (btn_down_pulse)
            win = DIR_DOWN;
        else if (btn_left_pulse)
            win = DIR_LEFT;
        newest_ptr = (wr_ptr == 2'd0) ? LAST_PTR : wr_ptr - 2'd1;
        // Reference is the newest pending turn, so chained turns are validated against each other.
        ref_dir    = (queue_count != 3'd0) ? q[newest_ptr] : dir;
        accept     = running && any_btn && (win != ref_dir) && (win != (ref_dir ^ 2'b10));
        full       = (queue_count == FULL_CNT);
        pop        = running && game_tick && (queue_count != 3'd0);
        push       = accept && (!full || pop);
        drop       = accept && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dir         <= DIR_RIGHT;
            dir_changed <= 1'b0;
            start_pulse <= 1'b0;
            drop_pulse  <= 1'b0;
            queue_count <= 3'd0;
            rd_ptr      <= 2'd0;
            wr_ptr      <= 2'd0;
        end else begin
            state       <= state_nxt;
            start_pulse <= (state == IDLE) && any_btn;
            dir_changed <= pop;
            drop_pulse  <= drop;
            if (leaving) begin
                dir         <= DIR_RIGHT;
                queue_count <= 3'd0;
                rd_ptr      <= 2'd0;
                wr_ptr      <= 2'd0;
            end else begin
                if (pop) begin
                    dir    <= q[rd_ptr];
                    rd_ptr <= next_ptr(rd_ptr);
                end
                if (push) begin
                    q[wr_ptr] <= win;
                    wr_ptr    <= next_ptr(wr_ptr);
                end
                queue_count <= queue_count + {2'b00, push} - {2'b00, pop};
            end
        end
    end

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Bench for dir_input_ctrl: directed vector table for the listed scenarios, then random traffic against a queue model.
module tb_dir_input_ctrl;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst, up, down, left, right, game_active, game_tick;
    logic [1:0] dir;
    logic       dir_changed, start_pulse, drop_pulse;
    logic [2:0] queue_count;

    int checks = 0;
    int errors = 0;

    dir_input_ctrl #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .btn_up_pulse(up), .btn_down_pulse(down),
        .btn_left_pulse(left), .btn_right_pulse(right),
        .game_active(game_active), .game_tick(game_tick),
        .dir(dir), .dir_changed(dir_changed), .start_pulse(start_pulse),
        .drop_pulse(drop_pulse), .queue_count(queue_count)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic       r, ga, tk;
        logic [3:0] b;      // {up, down, left, right}
        logic [1:0] e_dir;
        logic       e_chg, e_start, e_drop;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: game state, committed direction and a plain queue of pending turns.
    bit         m_run;
    logic [1:0] m_dir;
    logic [1:0] mq[$];
    logic       m_chg, m_start, m_drop;

    function automatic vec_t mk(logic r, logic ga, logic tk, logic [3:0] b,
                                logic [1:0] d, logic c, logic s, logic dr, logic [2:0] n);
        vec_t v;
        v.r = r; v.ga = ga; v.tk = tk; v.b = b;
        v.e_dir = d; v.e_chg = c; v.e_start = s; v.e_drop = dr; v.e_cnt = n;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic ga, input logic tk, input logic [3:0] b);
        logic [1:0] win, refd;
        bit acc, was_full, popped;
        m_chg = 0; m_start = 0; m_drop = 0;
        if (r) begin
            m_run = 0; m_dir = 2'b01; mq.delete();
        end else if (!m_run) begin
            m_start = |b;
            m_run = ga;
        end else if (!ga) begin
            m_run = 0; mq.delete(); m_dir = 2'b01;
        end else begin
            win  = b[3] ? 2'b00 : b[2] ? 2'b10 : b[1] ? 2'b11 : 2'b01;
            refd = (mq.size() > 0) ? mq[$] : m_dir;
            acc  = (|b) && (win != refd) && (win != (refd ^ 2'b10));
            was_full = (mq.size() == DEPTH);
            popped   = tk && (mq.size() > 0);
            if (popped) begin
                m_dir = mq.pop_front();
                m_chg = 1;
            end
            if (acc) begin
                if (!was_full || popped) mq.push_back(win);
                else m_drop = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ga, input logic tk, input logic [3:0] b);
        @(negedge clk);
        rst = r; game_active = ga; game_tick = tk;
        {up, down, left, right} = b;
        model_step(r, ga, tk, b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; up = 0; down = 0; left = 0; right = 0;
        game_active = 0; game_tick = 0;
        m_run = 0; m_dir = 2'b01;

        //              r  ga tk btn      dir chg st dr cnt
        vecs.push_back(mk(1, 0, 0, 4'b0000, 1, 0, 0, 0, 0)); // reset
        vecs.push_back(mk(0, 0, 0, 4'b0010, 1, 0, 1, 0, 0)); // idle left -> start
        vecs.push_back(mk(0, 0, 1, 4'b0000, 1, 0, 0, 0, 0)); // start is one cycle, tick ignored
        vecs.push_back(mk(0, 1, 0, 4'b0000, 1, 0, 0, 0, 0)); // enter run
        vecs.push_back(mk(0, 1, 0, 4'b0010, 1, 0, 0, 0, 0)); // reversal rejected
        vecs.push_back(mk(0, 1, 0, 4'b0001, 1, 0, 0, 0, 0)); // redundant rejected
        vecs.push_back(mk(0, 1, 0, 4'b1000, 1, 0, 0, 0, 1)); // up queued
        vecs.push_back(mk(0, 1, 1, 4'b0000, 0, 1, 0, 0, 0)); // tick commits up
        vecs.push_back(mk(0, 1, 0, 4'b0000, 0, 0, 0, 0, 0)); // dir_changed single cycle
        vecs.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 0, 0, 0)); // leave run -> dir 01
        vecs.push_back(mk(0, 1, 0, 4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'b1000, 1, 0, 0, 0, 1)); // up
        vecs.push_back(mk(0, 1, 0, 4'b0010, 1, 0, 0, 0, 2)); // left vs newest 00
        vecs.push_back(mk(0, 1, 0, 4'b0100, 1, 0, 0, 1, 2)); // down, full -> drop
        vecs.push_back(mk(0, 1, 0, 4'b0000, 1, 0, 0, 0, 2)); // drop single cycle
        vecs.push_back(mk(0, 1, 1, 4'b0100, 0, 1, 0, 0, 2)); // pop+push on full
        vecs.push_back(mk(0, 1, 1, 4'b0000, 3, 1, 0, 0, 1)); // commit left
        vecs.push_back(mk(0, 1, 1, 4'b0000, 2, 1, 0, 0, 0)); // commit down (wrapped entry)
        vecs.push_back(mk(0, 1, 1, 4'b0000, 2, 0, 0, 0, 0)); // empty tick holds
        vecs.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'b0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'b1100, 1, 0, 0, 0, 1)); // up+down -> up only
        vecs.push_back(mk(0, 1, 1, 4'b0000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'b0010, 0, 0, 0, 0, 1)); // push into empty with tick not popped
        vecs.push_back(mk(0, 1, 0, 4'b1000, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 1, 4'b0100, 1, 0, 0, 0, 0)); // reset overrides mid-game
        vecs.push_back(mk(0, 0, 1, 4'b0000, 1, 0, 0, 0, 0)); // idle tick ignored
        vecs.push_back(mk(0, 0, 0, 4'b1001, 1, 0, 1, 0, 0)); // idle multi-press -> start

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].ga, vecs[i].tk, vecs[i].b);
            check($sformatf("vec%0d dir", i), {1'b0, dir}, {1'b0, vecs[i].e_dir});
            check($sformatf("vec%0d dir_changed", i), {2'b0, dir_changed}, {2'b0, vecs[i].e_chg});
            check($sformatf("vec%0d start_pulse", i), {2'b0, start_pulse}, {2'b0, vecs[i].e_start});
            check($sformatf("vec%0d drop_pulse", i), {2'b0, drop_pulse}, {2'b0, vecs[i].e_drop});
            check($sformatf("vec%0d queue_count", i), queue_count, vecs[i].e_cnt);
        end

        begin
            logic ga_r;
            ga_r = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                logic       r_r, tk_r;
                logic [3:0] b_r;
                if ($urandom_range(0, 49) == 0) ga_r = ~ga_r;
                r_r  = ($urandom_range(0, 199) == 0);
                tk_r = ($urandom_range(0, 3) == 0);
                for (int k = 0; k < 4; k++) b_r[k] = ($urandom_range(0, 3) == 0);
                drive(r_r, ga_r, tk_r, b_r);
                check("rand dir", {1'b0, dir}, {1'b0, m_dir});
                check("rand dir_changed", {2'b0, dir_changed}, {2'b0, m_chg});
                check("rand start_pulse", {2'b0, start_pulse}, {2'b0, m_start});
                check("rand drop_pulse", {2'b0, drop_pulse}, {2'b0, m_drop});
                check("rand queue_count", queue_count, 3'(mq.size()));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
